// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the ID/EX pipeline slice.
//   - CPU_DATA_W / CPU_REG_AW / CPU_OP_W : default datapath widths
//   - OP_NOP / OP_ADD                    : ALU opcode constants
//   - id_ex_t                            : contents of the ID/EX pipeline register
//   - fwd_sel_t                          : operand source chosen by forwarding
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_REG_AW = 4;
    localparam int CPU_OP_W   = 4;

    localparam logic [CPU_OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [CPU_OP_W-1:0] OP_ADD = 4'b0001;

    typedef struct packed {
        logic                  valid;
        logic [CPU_OP_W-1:0]   aluOp;
        logic [CPU_REG_AW-1:0] rs1;
        logic [CPU_REG_AW-1:0] rs2;
        logic [CPU_REG_AW-1:0] rd;
        logic [CPU_DATA_W-1:0] rdA;
        logic [CPU_DATA_W-1:0] rdB;
        logic                  useImm;
        logic [CPU_DATA_W-1:0] imm;
        logic                  memRead;
        logic                  regWrite;
    } id_ex_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// ----------------------------------------------------------------------------
// forward_unit
// Combinational operand forwarding for one source register.
// Ports:
//   rs           in  source register address
//   reg_data     in  registered regfile read data for rs
//   mem_regWrite in  EX/MEM writes back     mem_rd in  EX/MEM destination
//   mem_result   in  EX/MEM result
//   wb_regWrite  in  MEM/WB writes back     wb_rd  in  MEM/WB destination
//   wb_result    in  MEM/WB writeback value
//   sel          out chosen source (FWD_REG / FWD_MEM / FWD_WB)
//   value        out operand value after forwarding
// ----------------------------------------------------------------------------
module forward_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output fwd_sel_t          sel,
    output logic [DATA_W-1:0] value
);

    // Priority select: r0 is hard zero, then the younger MEM result, then WB.
    // Because rs is nonzero past the first branch, rd==rs implies rd!=0.
    always_comb begin
        sel   = FWD_REG;
        value = reg_data;
        if (rs == {REG_AW{1'b0}}) begin
            sel   = FWD_REG;
            value = {DATA_W{1'b0}};
        end else if (mem_regWrite && (mem_rd == rs)) begin
            sel   = FWD_MEM;
            value = mem_result;
        end else if (wb_regWrite && (wb_rd == rs)) begin
            sel   = FWD_WB;
            value = wb_result;
        end else begin
            sel   = FWD_REG;
            value = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand select feeding the ALU.
// Captures decode each cycle, forwards from EX/MEM and MEM/WB, detects
// load-use hazards (one-cycle stall with a bubble) and flushes on redirect.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush cycle counters.
// Ports:
//   clk, rst (sync, active-high), flush
//   id_*          decoded instruction fields and regfile read data
//   mem_* / wb_*  writeback info from EX/MEM and MEM/WB for forwarding
//   stall_id      out, combinational: hold PC and IF/ID
//   ex_valid, aluOp, srcA, srcB, ex_rd, ex_regWrite, ex_memRead  EX outputs
//   stall_cnt, flush_cnt  (only with ID_EX_PERF_CNT_EN)
// ----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW,
    parameter int OP_W   = CPU_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_aluOp,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdA,
    input  logic [DATA_W-1:0] id_rdB,
    input  logic              id_useImm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_memRead,
    input  logic              id_regWrite,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [OP_W-1:0]   aluOp,
    output logic [DATA_W-1:0] srcA,
    output logic [DATA_W-1:0] srcB,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regWrite,
    output logic              ex_memRead
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    id_ex_t            ex_r;
    logic              hazard_s;
    fwd_sel_t          sel_a_s;
    fwd_sel_t          sel_b_s;
    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;

    // Load-use hazard against the load sitting in EX; flush overrides it.
    always_comb begin
        hazard_s = ex_r.valid && ex_r.memRead && (ex_r.rd != {REG_AW{1'b0}}) && id_valid &&
                   ((id_rs1 == ex_r.rd) || (!id_useImm && (id_rs2 == ex_r.rd)));
        if (flush) begin
            stall_id = 1'b0;
        end else begin
            stall_id = hazard_s;
        end
    end

    // ID/EX register: bubble on flush, stall or empty decode, else capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r <= '0;
        end else if (flush || stall_id || !id_valid) begin
            ex_r <= '0;
        end else begin
            ex_r.valid    <= 1'b1;
            ex_r.aluOp    <= id_aluOp;
            ex_r.rs1      <= id_rs1;
            ex_r.rs2      <= id_rs2;
            ex_r.rd       <= id_rd;
            ex_r.rdA      <= id_rdA;
            ex_r.rdB      <= id_rdB;
            ex_r.useImm   <= id_useImm;
            ex_r.imm      <= id_imm;
            ex_r.memRead  <= id_memRead;
            ex_r.regWrite <= id_regWrite;
        end
    end

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .rs           (ex_r.rs1),
        .reg_data     (ex_r.rdA),
        .mem_regWrite (mem_regWrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .sel          (sel_a_s),
        .value        (fwd_a_s)
    );

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .rs           (ex_r.rs2),
        .reg_data     (ex_r.rdB),
        .mem_regWrite (mem_regWrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .sel          (sel_b_s),
        .value        (fwd_b_s)
    );

    // Operand select; a bubble drives zeros so the ALU output is zero too.
    // Forwarded values come straight from the live mem/wb buses.
    always_comb begin
        srcA = {DATA_W{1'b0}};
        srcB = {DATA_W{1'b0}};
        if (ex_r.valid) begin
            case (sel_a_s)
                FWD_MEM: srcA = mem_result;
                FWD_WB:  srcA = wb_result;
                default: srcA = fwd_a_s;
            endcase
            if (ex_r.useImm) begin
                srcB = ex_r.imm;
            end else begin
                case (sel_b_s)
                    FWD_MEM: srcB = mem_result;
                    FWD_WB:  srcB = wb_result;
                    default: srcB = fwd_b_s;
                endcase
            end
        end else begin
            srcA = {DATA_W{1'b0}};
            srcB = {DATA_W{1'b0}};
        end
    end

    assign ex_valid    = ex_r.valid;
    assign aluOp       = ex_r.valid ? ex_r.aluOp : OP_NOP;
    assign ex_rd       = ex_r.rd;
    assign ex_regWrite = ex_r.valid & ex_r.regWrite;
    assign ex_memRead  = ex_r.valid & ex_r.memRead;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating cycle counters for stall_id and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (stall_id && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end
            if (flush && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule
